// File: rtl/dff_err_scan.sv
`timescale 1ns/1ps
// dff_err_scan: per-chain DFF error counters, snapshot frame and Pi-clocked serial readout.
// Define ERR_PARITY_EN to follow each channel field with an even-parity bit.
module dff_err_scan #(
    parameter int unsigned N_CH  = 20,
    parameter int unsigned CNT_W = 12,
    parameter int unsigned LAT   = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            DATA,
    input  logic [N_CH-1:0] Q,
    input  logic            EN,
    input  logic            SAVE_DATA,
    input  logic            DATA_CLK,
    output logic            DATA_OUT,
    output logic [N_CH-1:0] COMP_OUT,
    output logic            BUSY
);

`ifdef ERR_PARITY_EN
    localparam int unsigned FIELD_W = CNT_W + 1;
`else
    localparam int unsigned FIELD_W = CNT_W;
`endif
    localparam int unsigned FRAME_W = N_CH * FIELD_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    logic [LAT-1:0]     exp_line;
    logic               exp_bit;
    logic [N_CH-1:0]    mismatch;
    logic [N_CH-1:0]    hit;

    logic [2:0]         save_sync;
    logic [2:0]         shift_sync;
    logic               save_p;
    logic               shift_p;

    logic [CNT_W-1:0]   cnt [N_CH];
    logic [FRAME_W-1:0] snap;

    state_t             state;
    state_t             state_n;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] frame_n;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_n;

    // Expected-data delay line matching the DUT chain latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            exp_line <= '0;
        end else begin
            exp_line[0] <= DATA;
            for (int unsigned i = 1; i < LAT; i++) begin
                exp_line[i] <= exp_line[i-1];
            end
        end
    end

    always_comb begin
        exp_bit  = exp_line[LAT-1];
        mismatch = Q ^ {N_CH{exp_bit}};
        hit      = COMP_OUT & {N_CH{EN}};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            COMP_OUT <= '0;
        end else begin
            COMP_OUT <= mismatch;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            save_sync  <= '0;
            shift_sync <= '0;
        end else begin
            save_sync  <= {save_sync[1:0], SAVE_DATA};
            shift_sync <= {shift_sync[1:0], DATA_CLK};
        end
    end

    always_comb begin
        save_p  = save_sync[1] & ~save_sync[2];
        shift_p = shift_sync[1] & ~shift_sync[2];
    end

    // A save restarts the window; an error qualifying in that same cycle opens it at 1.
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (RST) begin
                cnt[i] <= '0;
            end else if (save_p) begin
                cnt[i] <= CNT_W'(hit[i]);
            end else if (hit[i] && (cnt[i] != '1)) begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    // Channel 0 lands in the frame MSBs so it is shifted out first.
    always_comb begin
        snap = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
`ifdef ERR_PARITY_EN
            snap[FRAME_W-1-i*FIELD_W -: FIELD_W] = {cnt[i], ^cnt[i]};
`else
            snap[FRAME_W-1-i*FIELD_W -: FIELD_W] = cnt[i];
`endif
        end
    end

    always_comb begin
        state_n   = state;
        frame_n   = frame;
        bit_cnt_n = bit_cnt;
        if (save_p) begin
            frame_n   = snap;
            bit_cnt_n = '0;
            state_n   = ST_SHIFT;
        end else if (shift_p && (state == ST_SHIFT)) begin
            frame_n   = {frame[FRAME_W-2:0], 1'b0};
            bit_cnt_n = bit_cnt + BIT_W'(1);
            if (bit_cnt_n == BIT_W'(FRAME_W)) begin
                state_n = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            frame   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            frame   <= frame_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    always_comb begin
        BUSY     = (state == ST_SHIFT);
        DATA_OUT = frame[FRAME_W-1];
    end

endmodule
